// File: rtl/ftsd_pkg.sv
// Glyph codes and the fourteen-segment glyph table for the ftsd scan driver.
package ftsd_pkg;
   localparam int GLYPH_W = 15;
   localparam logic [GLYPH_W-1:0] SEG_OFF = '1;

   localparam int CODE_DASH     = 16;
   localparam int CODE_BLANK    = 17;
   localparam int CODE_LET_BASE = 18;  // G H I J K L M N O P Q R S T U V W Y
   localparam int CODE_LET_LAST = 35;

   // Active-high pattern, bit order a b c d e f g1 g2 h i j k l m; dp is never lit.
   function automatic logic [13:0] glyph_pat(input int unsigned code);
      case (code)
         0:  glyph_pat = 14'h003F;
         1:  glyph_pat = 14'h0006;
         2:  glyph_pat = 14'h00DB;
         3:  glyph_pat = 14'h008F;
         4:  glyph_pat = 14'h00E6;
         5:  glyph_pat = 14'h00ED;
         6:  glyph_pat = 14'h00FD;
         7:  glyph_pat = 14'h0007;
         8:  glyph_pat = 14'h00FF;
         9:  glyph_pat = 14'h00EF;
         10: glyph_pat = 14'h00F7;
         11: glyph_pat = 14'h00FC;
         12: glyph_pat = 14'h0039;
         13: glyph_pat = 14'h00DE;
         14: glyph_pat = 14'h00F9;
         15: glyph_pat = 14'h00F1;
         CODE_DASH:  glyph_pat = 14'h00C0;
         CODE_BLANK: glyph_pat = 14'h0000;
         18: glyph_pat = 14'h00BD;
         19: glyph_pat = 14'h00F6;
         20: glyph_pat = 14'h1209;
         21: glyph_pat = 14'h001E;
         22: glyph_pat = 14'h2470;
         23: glyph_pat = 14'h0038;
         24: glyph_pat = 14'h0536;
         25: glyph_pat = 14'h2136;
         26: glyph_pat = 14'h003F;
         27: glyph_pat = 14'h00F3;
         28: glyph_pat = 14'h203F;
         29: glyph_pat = 14'h20F3;
         30: glyph_pat = 14'h00ED;
         31: glyph_pat = 14'h1201;
         32: glyph_pat = 14'h003E;
         33: glyph_pat = 14'h0C30;
         34: glyph_pat = 14'h2836;
         CODE_LET_LAST: glyph_pat = 14'h1500;
         default: glyph_pat = 14'h0000;
      endcase
   endfunction
endpackage

// File: rtl/ftsd_glyph_decode.sv
// Combinational glyph code to active-low segment pattern; unknown codes are dark.
module ftsd_glyph_decode
   import ftsd_pkg::*;
#(
   parameter int CODE_W = 6,
   parameter int SEG_W  = 15
) (
   input  logic [CODE_W-1:0] code,
   output logic [SEG_W-1:0]  seg
);
   logic [SEG_W+GLYPH_W-1:0] ext;

   // Segment lines beyond the table width are held dark.
   always_comb begin
      ext = {{SEG_W{1'b1}}, SEG_OFF ^ {1'b0, glyph_pat(32'(code))}};
      seg = ext[SEG_W-1:0];
   end
endmodule

// File: rtl/ftsd_scan_mux.sv
// N-digit multiplexed fourteen-segment driver: double-buffered frames, blanking, PWM.
// Optional macro LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 excepted).
module ftsd_scan_mux
   import ftsd_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int CODE_W    = 6,
   parameter int SEG_W     = 15,
   parameter int SCAN_DIV  = 10000,
   parameter int PWM_STEPS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DIGITS*CODE_W-1:0]     digit_codes,
   input  logic [DIGITS-1:0]            blank_mask,
   input  logic [$clog2(PWM_STEPS)-1:0] bright,
   input  logic                         update,
   output logic [DIGITS-1:0]            ftsd_ctl,
   output logic [SEG_W-1:0]             display,
   output logic                         frame_done
);
   localparam int CNT_W = $clog2(SCAN_DIV + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BR_W  = $clog2(PWM_STEPS);

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     first_q, first_d;
   logic [DIGITS*CODE_W-1:0] act_codes_q, act_codes_d, pend_codes_q, pend_codes_d;
   logic [DIGITS-1:0]        act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
   logic [BR_W-1:0]          act_bright_q, act_bright_d, pend_bright_q, pend_bright_d;
   logic                     pend_vld_q, pend_vld_d;
   logic [DIGITS-1:0]        ctl_q, ctl_d;
   logic [SEG_W-1:0]         disp_q, disp_d;
   logic                     frame_done_q, frame_done_d;

   logic                     slot_wrap, frame_wrap, load, en;
   logic [DIGITS-1:0]        eff_blank;
   logic [CODE_W-1:0]        cur_code;
   logic [SEG_W-1:0]         cur_seg;
   logic [CNT_W-1:0]         thr_lut [PWM_STEPS];

   // Constant-folded on-time thresholds, one per brightness level.
   always_comb begin
      for (int s = 0; s < PWM_STEPS; s++)
         thr_lut[s] = CNT_W'((s + 1) * SCAN_DIV / PWM_STEPS);
   end

`ifdef LEADING_ZERO_SUPPRESS_EN
   logic [DIGITS-1:0] lz_mask;
   logic              zero_run;
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_run   = zero_run && (act_codes_q[i*CODE_W +: CODE_W] == '0);
         lz_mask[i] = zero_run;
      end
   end
   assign eff_blank = act_blank_q | lz_mask;
`else
   assign eff_blank = act_blank_q;
`endif

   assign cur_code = act_codes_q[idx_q*CODE_W +: CODE_W];

   ftsd_glyph_decode #(.CODE_W(CODE_W), .SEG_W(SEG_W)) u_dec (
      .code (cur_code),
      .seg  (cur_seg)
   );

   always_comb begin
      slot_wrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      frame_wrap = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));
      load       = frame_wrap || first_q;
      cnt_d      = slot_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (slot_wrap)
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      first_d       = 1'b0;
      act_codes_d   = act_codes_q;
      act_blank_d   = act_blank_q;
      act_bright_d  = act_bright_q;
      pend_codes_d  = pend_codes_q;
      pend_blank_d  = pend_blank_q;
      pend_bright_d = pend_bright_q;
      pend_vld_d    = pend_vld_q;
      // An update landing on the boundary bypasses pending and starts this frame.
      if (load) begin
         if (update) begin
            act_codes_d  = digit_codes;
            act_blank_d  = blank_mask;
            act_bright_d = bright;
         end else if (pend_vld_q) begin
            act_codes_d  = pend_codes_q;
            act_blank_d  = pend_blank_q;
            act_bright_d = pend_bright_q;
         end
         pend_vld_d = 1'b0;
      end else if (update) begin
         pend_codes_d  = digit_codes;
         pend_blank_d  = blank_mask;
         pend_bright_d = bright;
         pend_vld_d    = 1'b1;
      end
      en           = !eff_blank[idx_q] && (cnt_q < thr_lut[act_bright_q]);
      ctl_d        = en ? ~(DIGITS'(1) << idx_q) : '1;
      disp_d       = en ? cur_seg : '1;
      frame_done_d = frame_wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         first_q       <= 1'b1;
         act_codes_q   <= '0;
         act_blank_q   <= '1;
         act_bright_q  <= '0;
         pend_codes_q  <= '0;
         pend_blank_q  <= '0;
         pend_bright_q <= '0;
         pend_vld_q    <= 1'b0;
         ctl_q         <= '1;
         disp_q        <= '1;
         frame_done_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         first_q       <= first_d;
         act_codes_q   <= act_codes_d;
         act_blank_q   <= act_blank_d;
         act_bright_q  <= act_bright_d;
         pend_codes_q  <= pend_codes_d;
         pend_blank_q  <= pend_blank_d;
         pend_bright_q <= pend_bright_d;
         pend_vld_q    <= pend_vld_d;
         ctl_q         <= ctl_d;
         disp_q        <= disp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign ftsd_ctl   = ctl_q;
   assign display    = disp_q;
   assign frame_done = frame_done_q;
endmodule
